// File: rtl/sha_mem_pkg.sv
// Shared definitions for the SHA-256 memory arbitration slice: default widths,
// requester slot assignments, arbiter state encoding and the round-robin pick.
package sha_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 32;

  // Fixed requester slots on the shared K/H/message memory port.
  localparam int REQ_WEXP   = 0;
  localparam int REQ_COMP   = 1;
  localparam int REQ_DIGEST = 2;
  localparam int REQ_LOAD   = 3;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // First requesting index at or after ptr, wrapping modulo n (n <= 8).
  // Returns -1 when nothing is requesting.
  function automatic int rr_pick_fn(input logic [7:0] req, input int ptr, input int n);
    int pick;
    int j;
    pick = -1;
    for (int k = 0; k < 8; k++) begin
      j = (ptr + k) % n;
      if (k < n && pick < 0 && req[j[2:0]]) pick = j;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-side bundle of the shared memory port; the arbiter
// takes the slave view, the requesters and SRAM together form the master view.
interface sram_port_arbiter_if import sha_mem_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          sram_enable;
  logic                          sram_write;
  logic [ADDR_WIDTH-1:0]         sram_address;
  logic [DATA_WIDTH-1:0]         sram_wdata;
  logic [DATA_WIDTH-1:0]         sram_rdata;

  modport slave (
    input  req, lock, req_addr, req_write, req_wdata, sram_rdata,
    output gnt, rvalid, rdata, sram_enable, sram_write, sram_address, sram_wdata
  );

  modport master (
    output req, lock, req_addr, req_write, req_wdata, sram_rdata,
    input  gnt, rvalid, rdata, sram_enable, sram_write, sram_address, sram_wdata
  );

endinterface

// File: rtl/sram_port_arbiter_rr_pick.sv
// Rotating-priority encoder: finds the first set request at or after the
// round-robin pointer and returns it both one-hot and as an index.
module rr_pick import sha_mem_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int sel;

  always_comb begin
    sel      = rr_pick_fn(8'(req_i), int'(ptr_i), NUM_REQ);
    valid_o  = (sel >= 0);
    idx_o    = valid_o ? IDX_W'(sel) : '0;
    onehot_o = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for one single-port SHA-256 memory with optional capped
// burst locking; SRAM controls are registered and read data returns two cycles after grant.
module sram_port_arbiter import sha_mem_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  sram_port_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]     tag1_q, tag2_q;
  logic                   sram_enable_q, sram_write_q;
  logic [ADDR_WIDTH-1:0]  sram_address_q;
  logic [DATA_WIDTH-1:0]  sram_wdata_q;

  logic [NUM_REQ-1:0]     pick_onehot, gnt_d;
  logic [IDX_W-1:0]       pick_idx, grant_idx;
  logic                   pick_valid, grant_valid, hold;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_i    (bus.req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = '0;
    grant_idx   = pick_idx;
    grant_valid = 1'b0;

    hold = (state_q == ARB_LOCKED) && bus.req[owner_q] && bus.lock[owner_q]
           && (burst_cnt_q < CNT_W'(MAX_BURST));

    if (hold) begin
      grant_valid = 1'b1;
      grant_idx   = owner_q;
      gnt_d       = NUM_REQ'(1) << owner_q;
      burst_cnt_d = burst_cnt_q + 1'b1;
    end else begin
      // Released, capped or never locked: arbitrate normally in this same cycle.
      state_d     = ARB_FREE;
      burst_cnt_d = '0;
      if (pick_valid) begin
        grant_valid = 1'b1;
        gnt_d       = pick_onehot;
        rr_ptr_d    = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
        if (bus.lock[pick_idx] && (MAX_BURST > 1)) begin
          state_d     = ARB_LOCKED;
          owner_d     = pick_idx;
          burst_cnt_d = CNT_W'(1);
        end
      end
    end

    if (reset_i) gnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ARB_FREE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      burst_cnt_q    <= '0;
      tag1_q         <= '0;
      tag2_q         <= '0;
      sram_enable_q  <= 1'b0;
      sram_write_q   <= 1'b0;
      sram_address_q <= '0;
      sram_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      tag1_q        <= (grant_valid && !bus.req_write[grant_idx]) ? gnt_d : '0;
      tag2_q        <= tag1_q;
      sram_enable_q <= grant_valid;
      sram_write_q  <= grant_valid && bus.req_write[grant_idx];
      if (grant_valid) begin
        sram_address_q <= bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sram_wdata_q   <= bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.gnt          = gnt_d;
  assign bus.rvalid       = tag2_q;
  assign bus.rdata        = bus.sram_rdata;
  assign bus.sram_enable  = sram_enable_q;
  assign bus.sram_write   = sram_write_q;
  assign bus.sram_address = sram_address_q;
  assign bus.sram_wdata   = sram_wdata_q;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter sharing one single-port SRAM (K-constant, H-value or message memory) between up to NUM_REQ requesters inside the SHA-256 datapath, e.g. the W-schedule expander, the compression round logic and the digest writer. It accepts one access per cycle, registers the SRAM-side enable/address/write/data outputs, and returns read data tagged to the originating requester two cycles after grant. Optional burst locking lets a requester hold the port for consecutive accesses, capped to bound latency for the others.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 6, SRAM address width
- DATA_WIDTH, 32, SRAM word width
- MAX_BURST, 8, maximum consecutive grants to one locked requester (1..256)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- req  input  NUM_REQ  per-requester access request
- lock  input  NUM_REQ  per-requester burst-hold request, meaningful only with req
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- req_write  input  NUM_REQ  1 = write, 0 = read
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data
- gnt  output  NUM_REQ  one-hot (or zero) combinational grant, current cycle
- rvalid  output  NUM_REQ  one-hot read-data-valid
- rdata  output  DATA_WIDTH  read data, qualified by rvalid
- sram_enable  output  1  registered SRAM enable
- sram_write  output  1  registered SRAM write
- sram_address  output  ADDR_WIDTH  registered SRAM address
- sram_wdata  output  DATA_WIDTH  registered SRAM write data
- sram_rdata  input  DATA_WIDTH  SRAM read data, valid one cycle after sram_enable with sram_write=0

## Operation
- State: rr_ptr (highest-priority index), owner (index), owner_valid, burst_cnt (clog2(MAX_BURST)+1 bits).
- States: FREE (owner_valid=0) and LOCKED (owner_valid=1).
- FREE: grant lowest index i ≥ rr_ptr (wrapping modulo NUM_REQ) with req[i]=1. On grant: rr_ptr <= i+1 mod NUM_REQ. If lock[i]=1 and MAX_BURST>1, go LOCKED, owner <= i, burst_cnt <= 1.
- LOCKED: if req[owner]=1 and lock[owner]=1 and burst_cnt < MAX_BURST, grant owner, burst_cnt += 1. Otherwise leave LOCKED and arbitrate as FREE in the same cycle (no dead cycle); a locked requester that stays locked after hitting the cap is treated as an ordinary requester, rr_ptr already past it.
- LOCKED with req[owner]=0: release, arbitrate FREE same cycle.
- No req: gnt=0, sram_enable <= 0, pointer and state unchanged.
- Granted access: requester i's addr/write/wdata captured into sram_* registers; requester may change inputs the cycle after gnt.
- Reads: a one-hot tag pipeline follows the access; rvalid[i]=1 and rdata=sram_rdata two cycles after gnt[i]. Writes produce no rvalid.
- rdata is a straight pass-through of sram_rdata; undefined when rvalid=0.

## Timing
- Cycle N: req sampled, gnt driven combinationally from registered state + req/lock.
- N+1: sram_enable/write/address/wdata reflect the grant.
- N+2: rvalid/rdata for reads. Throughput one access per cycle, back-to-back across requesters.
- Reset values: gnt=0 (forced while reset), rvalid=0, sram_enable=0, sram_write=0, sram_address=0, sram_wdata=0, rr_ptr=0, owner_valid=0, burst_cnt=0.
- Reset mid-operation: in-flight tags cleared; no rvalid in the two cycles after reset even if grants preceded it.
- Worst-case wait for any requester with req held: (NUM_REQ−1)*MAX_BURST cycles.

## Structure
- Shared package sha_mem_pkg: ADDR_WIDTH/DATA_WIDTH defaults, requester index constants (REQ_WEXP, REQ_COMP, REQ_DIGEST, REQ_LOAD), function for wrapping round-robin pick.
- One sub-module: rr_pick (combinational rotate-priority encoder, inputs req vector and rr_ptr, outputs one-hot and index).

## Test plan
- Single read: reset, req[2]=1 addr=5 for one cycle, sram_rdata model returns 0xDEADBEEF -> gnt=0100 at N, sram_enable=1 addr=5 at N+1, rvalid=0100 rdata=0xDEADBEEF at N+2.
- Round-robin: req=1111 held 8 cycles, no lock -> grants 0,1,2,3,0,1,2,3; sram_address tracks each requester's address.
- Burst cap: MAX_BURST=8, req[1]=lock[1]=1 and req[3]=1 held -> eight grants to 1, then grant 3, then 1 again.
- Lock release: lock[0] locked for 3 grants then req[0] dropped with req[2]=1 -> grant 2 on the next cycle, no bubble.
- Write no-return: req[3] write addr=9 wdata=0x12345678 -> sram_write=1, wdata correct at N+1, rvalid stays 0.
- Reset mid-flight: grant read at N, reset asserted N+1 -> rvalid=0 at N+2, all sram_* zero, next grant order starts at requester 0.
